// File: rtl/mem_queue_stage_if.sv
// mem_queue_stage_if: shared memory-op types plus the EX/WB/MMU signal bundle of mem_queue_stage.
package mem_queue_pkg;
    typedef enum logic [1:0] {
        MEM_NOP    = 2'd0,
        MEM_LOAD_S = 2'd1,
        MEM_LOAD_U = 2'd2,
        MEM_STORE  = 2'd3
    } mem_type_t;
    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;
endpackage

interface mem_queue_stage_if;
    import mem_queue_pkg::*;
    logic        flush;
    logic        ex_valid;
    logic        ex_both_ready;
    logic [31:0] ex_pc;
    logic [31:0] ex_result;
    logic [4:0]  ex_dest;
    logic [31:0] ex_addr;
    mem_type_t   ex_mem_type;
    mem_size_t   ex_mem_size;
    logic        ex_got_data_ok;
    logic [31:0] ex_ld_data;
    logic        mem_ready;
    logic        mem_stall;
    logic        allowout;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic [31:0] mem_result;
    logic [4:0]  mem_dest;
    logic        mem_forwardable;
    logic        mmu_data_ok;
    logic [31:0] mmu_rdata;

    modport master (
        output flush, ex_valid, ex_both_ready, ex_pc, ex_result, ex_dest, ex_addr,
               ex_mem_type, ex_mem_size, ex_got_data_ok, ex_ld_data, allowout,
               mmu_data_ok, mmu_rdata,
        input  mem_ready, mem_stall, mem_valid, mem_pc, mem_result, mem_dest, mem_forwardable
    );
    modport slave (
        input  flush, ex_valid, ex_both_ready, ex_pc, ex_result, ex_dest, ex_addr,
               ex_mem_type, ex_mem_size, ex_got_data_ok, ex_ld_data, allowout,
               mmu_data_ok, mmu_rdata,
        output mem_ready, mem_stall, mem_valid, mem_pc, mem_result, mem_dest, mem_forwardable
    );
endinterface

// File: rtl/mem_queue_stage.sv
// mem_queue_stage: in-order DEPTH-entry MEM queue between EX and WB with load extraction and
// flush-safe response accounting. Define MEM_QUEUE_BYPASS_EN to let a head that receives its
// data_ok this cycle complete and retire in the same cycle.
module mem_queue_stage
    import mem_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic              clk,
    input logic              resetn,
    mem_queue_stage_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic [4:0]  dest;
        logic [1:0]  addr;
        mem_type_t   mtype;
        mem_size_t   msize;
        logic [31:0] data;
    } entry_t;

    entry_t           entry_q [DEPTH];
    entry_t           entry_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d, discard_q, discard_d;

    logic [PW-1:0]    idx, oldest;
    logic             found;
    logic [CW-1:0]    n_wait;
    entry_t           hd;
    logic             rsp_live, bypass, retire, enq, sgn, is_load;
    logic [31:0]      raw, ld_val;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic             unused_addr_hi;

    assign unused_addr_hi = ^bus.ex_addr[31:2];

    // Find the oldest waiting entry for response routing and count waiting entries for flushes.
    always_comb begin
        idx    = head_q;
        oldest = head_q;
        found  = 1'b0;
        n_wait = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (!found && valid_q[idx] && !done_q[idx]) begin
                found  = 1'b1;
                oldest = idx;
            end
            n_wait = n_wait + CW'(valid_q[i] & ~done_q[i]);
        end
    end

    // Head completion, load extraction and handshake outputs.
    always_comb begin
        hd       = entry_q[head_q];
        rsp_live = bus.mmu_data_ok && (discard_q == '0);
`ifdef MEM_QUEUE_BYPASS_EN
        bypass   = rsp_live && valid_q[head_q] && !done_q[head_q];
`else
        bypass   = 1'b0;
`endif
        raw      = bypass ? bus.mmu_rdata : hd.data;
        byte_v   = raw[{hd.addr, 3'b000} +: 8];
        half_v   = hd.addr[1] ? raw[31:16] : raw[15:0];
        sgn      = hd.mtype == MEM_LOAD_S;
        is_load  = sgn || hd.mtype == MEM_LOAD_U;
        ld_val   = hd.msize == MEM_BYTE ? {{24{sgn & byte_v[7]}}, byte_v}
                 : hd.msize == MEM_HALF ? {{16{sgn & half_v[15]}}, half_v} : raw;
        bus.mem_valid       = valid_q[head_q] && (done_q[head_q] || bypass) && !bus.flush;
        retire              = bus.mem_valid && bus.allowout;
        bus.mem_ready       = ({1'b0, count_q} + {1'b0, discard_q} < (CW+1)'(DEPTH)) || retire;
        bus.mem_stall       = !bus.mem_ready;
        enq                 = bus.ex_valid && bus.ex_both_ready && bus.mem_ready && !bus.flush;
        bus.mem_pc          = hd.pc;
        bus.mem_dest        = hd.dest;
        bus.mem_result      = is_load ? ld_val : hd.result;
        bus.mem_forwardable = valid_q[head_q] && hd.mtype == MEM_NOP;
    end

    // Next queue state: flush accounting, response routing, retire, then enqueue (may reuse the retired slot).
    always_comb begin
        valid_d   = valid_q;
        done_d    = done_q;
        entry_d   = entry_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        discard_d = discard_q;
        if (bus.flush) begin
            valid_d   = '0;
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            discard_d = discard_q + n_wait - CW'(bus.mmu_data_ok);
        end else begin
            if (bus.mmu_data_ok && !rsp_live) discard_d = discard_q - CW'(1);
            if (rsp_live && found) begin
                done_d[oldest]       = 1'b1;
                entry_d[oldest].data = bus.mmu_rdata;
            end
            if (retire) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + PW'(1);
            end
            if (enq) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = bus.ex_mem_type == MEM_NOP || bus.ex_got_data_ok;
                entry_d[tail_q] = '{pc: bus.ex_pc, result: bus.ex_result, dest: bus.ex_dest,
                                    addr: bus.ex_addr[1:0], mtype: bus.ex_mem_type,
                                    msize: bus.ex_mem_size, data: bus.ex_ld_data};
                tail_d          = tail_q + PW'(1);
            end
            count_d = count_q + CW'(enq) - CW'(retire);
        end
    end

    // Occupancy and accounting state; cleared asynchronously on reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q   <= '0;
            done_q    <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            discard_q <= '0;
        end else begin
            valid_q   <= valid_d;
            done_q    <= done_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            discard_q <= discard_d;
        end
    end

    // Payload storage, deliberately not reset.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end
endmodule

// File: tb/tb_mem_queue_stage.sv
// tb_mem_queue_stage: directed scenario bench for mem_queue_stage (DEPTH=4), either bypass build.
module tb_mem_queue_stage;
    import mem_queue_pkg::*;
`ifdef MEM_QUEUE_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mem_queue_stage_if bus();
    mem_queue_stage #(.DEPTH(4)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    // A response with nothing waiting and no discard backlog must never be produced.
    always @(negedge clk) begin
        if (resetn && bus.mmu_data_ok && dut.discard_q == '0 && (dut.valid_q & ~dut.done_q) == '0) begin
            errors++;
            $display("FAIL protocol stray data_ok at %0t", $time);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input mem_type_t t, input mem_size_t s, input logic [1:0] a,
                          input logic [31:0] r, input logic [4:0] d, input logic [31:0] p,
                          input logic got);
        bus.ex_valid       = 1'b1;
        bus.ex_both_ready  = 1'b1;
        bus.ex_mem_type    = t;
        bus.ex_mem_size    = s;
        bus.ex_addr        = {30'h0, a};
        bus.ex_result      = r;
        bus.ex_dest        = d;
        bus.ex_pc          = p;
        bus.ex_got_data_ok = got;
        bus.ex_ld_data     = r;
    endtask

    task automatic clr_ex();
        bus.ex_valid      = 1'b0;
        bus.ex_both_ready = 1'b0;
    endtask

    task automatic idle();
        clr_ex();
        bus.ex_pc          = '0;
        bus.ex_result      = '0;
        bus.ex_dest        = '0;
        bus.ex_addr        = '0;
        bus.ex_mem_type    = MEM_NOP;
        bus.ex_mem_size    = MEM_WORD;
        bus.ex_got_data_ok = 1'b0;
        bus.ex_ld_data     = '0;
        bus.flush          = 1'b0;
        bus.allowout       = 1'b0;
        bus.mmu_data_ok    = 1'b0;
        bus.mmu_rdata      = '0;
    endtask

    task automatic test_reset();
        idle();
        resetn = 1'b0;
        #2;
        checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", bus.mem_valid); end
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", bus.mem_ready); end
        checks++; if (bus.mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", bus.mem_stall); end
        checks++; if (bus.mem_forwardable !== 1'b0) begin errors++; $display("FAIL reset_fwd got=%0b exp=0", bus.mem_forwardable); end
        step();
        step();
        resetn = 1'b1;
        #1;
        checks++; if (dut.count_q !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", dut.count_q); end
        checks++; if (dut.discard_q !== 3'd0) begin errors++; $display("FAIL reset_discard got=%0d exp=0", dut.discard_q); end
    endtask

    task automatic test_load_byte();
        step();
        set_ex(MEM_LOAD_S, MEM_BYTE, 2'b11, 32'h0, 5'd5, 32'h100, 1'b0);
        #1;
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL lb_ready got=%0b exp=1", bus.mem_ready); end
        step();
        clr_ex();
        #1;
        checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL lb_wait_valid got=%0b exp=0", bus.mem_valid); end
        bus.allowout  = 1'b1;
        bus.mmu_rdata = 32'h80123456;
        for (int i = 0; i < 3; i++) begin
            bus.mmu_data_ok = (i == 0);
            #1;
            checks++; if (bus.mem_valid !== (i == LAT)) begin errors++; $display("FAIL lb_valid cyc=%0d got=%0b exp=%0b", i, bus.mem_valid, i == LAT); end
            if (i == LAT) begin
                checks++; if (bus.mem_result !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_result got=%h exp=ffffff80", bus.mem_result); end
                checks++; if (bus.mem_dest !== 5'd5 || bus.mem_pc !== 32'h100) begin errors++; $display("FAIL lb_dest_pc got=%0d/%h exp=5/100", bus.mem_dest, bus.mem_pc); end
            end
            step();
        end
        bus.allowout = 1'b0;
    endtask

    task automatic test_fill();
        int e;
        step();
        bus.allowout = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_ex(MEM_STORE, MEM_WORD, 2'b00, 32'hA0 + 32'(i), 5'(i + 1), 32'h200 + 32'(4 * i), 1'b0);
            #1;
            checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL fill_ready i=%0d got=%0b exp=1", i, bus.mem_ready); end
            step();
        end
        set_ex(MEM_STORE, MEM_WORD, 2'b00, 32'hA4, 5'd5, 32'h210, 1'b0);
        #1;
        checks++; if (bus.mem_ready !== 1'b0 || bus.mem_stall !== 1'b1) begin errors++; $display("FAIL fill_full ready=%0b stall=%0b exp=0/1", bus.mem_ready, bus.mem_stall); end
        step();
        clr_ex();
        #1;
        checks++; if (dut.count_q !== 3'd4) begin errors++; $display("FAIL fill_held count got=%0d exp=4", dut.count_q); end
        bus.allowout = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.mmu_data_ok = (i < 4);
            bus.mmu_rdata   = 32'h5000 + 32'(i);
            #1;
            e = i - LAT;
            checks++; if (bus.mem_valid !== (e >= 0 && e < 4)) begin errors++; $display("FAIL fill_valid cyc=%0d got=%0b exp=%0b", i, bus.mem_valid, e >= 0 && e < 4); end
            if (e >= 0 && e < 4) begin
                checks++; if (bus.mem_result !== 32'hA0 + 32'(e) || bus.mem_dest !== 5'(e + 1)) begin errors++; $display("FAIL fill_order cyc=%0d got=%h/%0d exp=%h/%0d", i, bus.mem_result, bus.mem_dest, 32'hA0 + 32'(e), e + 1); end
            end
            step();
        end
        bus.mmu_data_ok = 1'b0;
        bus.allowout    = 1'b0;
        #1;
        checks++; if (dut.count_q !== 3'd0) begin errors++; $display("FAIL fill_drained count got=%0d exp=0", dut.count_q); end
    endtask

    task automatic test_full_swap();
        step();
        bus.allowout = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_ex(MEM_STORE, MEM_WORD, 2'b00, 32'hB0 + 32'(i), 5'(i + 10), 32'h300 + 32'(4 * i), 1'b1);
            step();
        end
        set_ex(MEM_STORE, MEM_WORD, 2'b00, 32'hB4, 5'd14, 32'h310, 1'b1);
        bus.allowout = 1'b1;
        #1;
        checks++; if (bus.mem_ready !== 1'b1 || bus.mem_valid !== 1'b1) begin errors++; $display("FAIL swap_hs ready=%0b valid=%0b exp=1/1", bus.mem_ready, bus.mem_valid); end
        checks++; if (bus.mem_result !== 32'hB0) begin errors++; $display("FAIL swap_head got=%h exp=b0", bus.mem_result); end
        step();
        clr_ex();
        #1;
        checks++; if (dut.count_q !== 3'd4) begin errors++; $display("FAIL swap_count got=%0d exp=4", dut.count_q); end
        for (int i = 1; i < 5; i++) begin
            checks++; if (bus.mem_valid !== 1'b1 || bus.mem_result !== 32'hB0 + 32'(i)) begin errors++; $display("FAIL swap_drain i=%0d got=%0b/%h exp=1/%h", i, bus.mem_valid, bus.mem_result, 32'hB0 + 32'(i)); end
            step();
            #1;
        end
        checks++; if (dut.count_q !== 3'd0 || bus.mem_valid !== 1'b0) begin errors++; $display("FAIL swap_empty count=%0d valid=%0b exp=0/0", dut.count_q, bus.mem_valid); end
        bus.allowout = 1'b0;
    endtask

    task automatic test_flush_discard();
        step();
        for (int i = 0; i < 2; i++) begin
            set_ex(MEM_LOAD_U, MEM_WORD, 2'b00, 32'h0, 5'(9 + i), 32'h400 + 32'(4 * i), 1'b0);
            step();
        end
        set_ex(MEM_STORE, MEM_WORD, 2'b00, 32'hEE, 5'd1, 32'h408, 1'b1);
        bus.flush       = 1'b1;
        bus.mmu_data_ok = 1'b1;
        bus.mmu_rdata   = 32'h0BAD0BAD;
        step();
        clr_ex();
        bus.flush       = 1'b0;
        bus.mmu_data_ok = 1'b0;
        #1;
        checks++; if (dut.discard_q !== 3'd1) begin errors++; $display("FAIL flush_discard got=%0d exp=1", dut.discard_q); end
        checks++; if (dut.count_q !== 3'd0 || bus.mem_valid !== 1'b0) begin errors++; $display("FAIL flush_empty count=%0d valid=%0b exp=0/0", dut.count_q, bus.mem_valid); end
        set_ex(MEM_LOAD_U, MEM_HALF, 2'b10, 32'h0, 5'd12, 32'h40C, 1'b0);
        bus.mmu_data_ok = 1'b1;
        bus.mmu_rdata   = 32'hDEADBEEF;
        step();
        clr_ex();
        bus.mmu_data_ok = 1'b0;
        #1;
        checks++; if (dut.discard_q !== 3'd0 || bus.mem_valid !== 1'b0) begin errors++; $display("FAIL flush_drop discard=%0d valid=%0b exp=0/0", dut.discard_q, bus.mem_valid); end
        bus.allowout  = 1'b1;
        bus.mmu_rdata = 32'h1234ABCD;
        for (int i = 0; i < 3; i++) begin
            bus.mmu_data_ok = (i == 0);
            #1;
            checks++; if (bus.mem_valid !== (i == LAT)) begin errors++; $display("FAIL flush_new_valid cyc=%0d got=%0b exp=%0b", i, bus.mem_valid, i == LAT); end
            if (i == LAT) begin
                checks++; if (bus.mem_result !== 32'h00001234 || bus.mem_dest !== 5'd12) begin errors++; $display("FAIL flush_new_result got=%h/%0d exp=00001234/12", bus.mem_result, bus.mem_dest); end
            end
            step();
        end
        bus.allowout = 1'b0;
    endtask

    task automatic test_nop_forward();
        step();
        bus.allowout = 1'b0;
        set_ex(MEM_NOP, MEM_WORD, 2'b00, 32'h77, 5'd7, 32'h500, 1'b0);
        step();
        set_ex(MEM_LOAD_S, MEM_WORD, 2'b00, 32'h0, 5'd8, 32'h504, 1'b0);
        step();
        clr_ex();
        #1;
        checks++; if (bus.mem_forwardable !== 1'b1 || bus.mem_valid !== 1'b1) begin errors++; $display("FAIL nop_fwd fwd=%0b valid=%0b exp=1/1", bus.mem_forwardable, bus.mem_valid); end
        checks++; if (bus.mem_result !== 32'h77 || bus.mem_dest !== 5'd7) begin errors++; $display("FAIL nop_result got=%h/%0d exp=77/7", bus.mem_result, bus.mem_dest); end
        bus.allowout = 1'b1;
        step();
        #1;
        checks++; if (bus.mem_valid !== 1'b0 || bus.mem_forwardable !== 1'b0 || dut.count_q !== 3'd1) begin errors++; $display("FAIL nop_retired valid=%0b fwd=%0b count=%0d exp=0/0/1", bus.mem_valid, bus.mem_forwardable, dut.count_q); end
        bus.mmu_rdata = 32'h80000055;
        for (int i = 0; i < 3; i++) begin
            bus.mmu_data_ok = (i == 0);
            #1;
            checks++; if (bus.mem_valid !== (i == LAT)) begin errors++; $display("FAIL nop_load_valid cyc=%0d got=%0b exp=%0b", i, bus.mem_valid, i == LAT); end
            if (i == LAT) begin
                checks++; if (bus.mem_result !== 32'h80000055) begin errors++; $display("FAIL nop_load_result got=%h exp=80000055", bus.mem_result); end
            end
            step();
        end
        bus.allowout = 1'b0;
    endtask

    task automatic test_async_reset();
        step();
        bus.allowout = 1'b0;
        set_ex(MEM_STORE, MEM_WORD, 2'b00, 32'hC0, 5'd1, 32'h600, 1'b1);
        step();
        set_ex(MEM_LOAD_U, MEM_WORD, 2'b00, 32'h0, 5'd2, 32'h604, 1'b0);
        step();
        set_ex(MEM_LOAD_U, MEM_WORD, 2'b00, 32'h0, 5'd3, 32'h608, 1'b0);
        step();
        set_ex(MEM_STORE, MEM_WORD, 2'b00, 32'hC3, 5'd4, 32'h60C, 1'b1);
        step();
        clr_ex();
        #1;
        checks++; if (bus.mem_valid !== 1'b1 || bus.mem_ready !== 1'b0) begin errors++; $display("FAIL ar_pre valid=%0b ready=%0b exp=1/0", bus.mem_valid, bus.mem_ready); end
        #1;
        resetn = 1'b0;
        #1;
        checks++; if (bus.mem_valid !== 1'b0 || bus.mem_ready !== 1'b1 || bus.mem_stall !== 1'b0) begin errors++; $display("FAIL ar_async valid=%0b ready=%0b stall=%0b exp=0/1/0", bus.mem_valid, bus.mem_ready, bus.mem_stall); end
        checks++; if (dut.count_q !== 3'd0 || dut.discard_q !== 3'd0) begin errors++; $display("FAIL ar_state count=%0d discard=%0d exp=0/0", dut.count_q, dut.discard_q); end
        #2;
        resetn = 1'b1;
        step();
        set_ex(MEM_LOAD_U, MEM_BYTE, 2'b00, 32'h0, 5'd6, 32'h700, 1'b0);
        step();
        clr_ex();
        bus.allowout  = 1'b1;
        bus.mmu_rdata = 32'h11223344;
        for (int i = 0; i < 3; i++) begin
            bus.mmu_data_ok = (i == 0);
            #1;
            checks++; if (bus.mem_valid !== (i == LAT)) begin errors++; $display("FAIL ar_after_valid cyc=%0d got=%0b exp=%0b", i, bus.mem_valid, i == LAT); end
            if (i == LAT) begin
                checks++; if (bus.mem_result !== 32'h00000044) begin errors++; $display("FAIL ar_after_result got=%h exp=00000044", bus.mem_result); end
            end
            step();
        end
        bus.allowout = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_fill();
        test_full_swap();
        test_flush_discard();
        test_nop_forward();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_queue_stage.md
Name: mem_queue_stage

Overview:
- Parametrised successor to the single-entry MEM stage: an in-order queue of up to DEPTH instructions between EX and WB.
- Lets several loads/stores have data_ok outstanding at once while EX keeps issuing.
- Performs load byte/half/word extraction and sign/zero extension at the head, and presents one retiring instruction per cycle to WB.
- Absorbs data_ok responses belonging to flushed instructions, so a flush never corrupts later entries.

Parameters:
- DEPTH, 4: queue entries; power of two, minimum 2. Also bounds total outstanding requests.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  kill all entries; ex_* ignored this cycle.
- ex_valid  in  1  EX holds a valid instruction.
- ex_both_ready  in  1  EX instruction complete and issuable.
- ex_pc  in  32  instruction PC.
- ex_result  in  32  ALU result or store passthrough.
- ex_dest  in  5  destination register.
- ex_addr  in  32  memory address; only [1:0] used.
- ex_mem_type  in  mem_type_t  MEM_NOP, MEM_LOAD_S, MEM_LOAD_U; any other value is a store.
- ex_mem_size  in  mem_size_t  MEM_BYTE, MEM_HALF, MEM_WORD.
- ex_got_data_ok  in  1  data_ok already received while in EX.
- ex_ld_data  in  32  data captured in EX when ex_got_data_ok=1.
- mem_ready  out  1  queue can accept this cycle.
- mem_stall  out  1  equals !mem_ready.
- allowout  in  1  WB accepts head this cycle.
- mem_valid  out  1  head valid and complete.
- mem_pc  out  32  head PC.
- mem_result  out  32  extended load data for loads, otherwise stored result.
- mem_dest  out  5  head destination.
- mem_forwardable  out  1  head valid and mem_type==MEM_NOP.
- mmu_data_ok  in  1  one response, returned in request order.
- mmu_rdata  in  32  response data.

Behaviour:
- Reset (resetn=0, asynchronous): all entry valid bits=0; head/tail pointers=0; count=0; discard_cnt=0.
  - Outputs during reset: mem_valid=0, mem_forwardable=0, mem_ready=1.
  - Payload registers are not reset.
- Entry fields: pc, result, dest, addr[1:0], type, size, done, data.
  - done = (type==MEM_NOP) || ex_got_data_ok at enqueue.
- Waiting entry: valid && !done. Only waiting entries own an outstanding request.
- mem_ready = (count + discard_cnt < DEPTH) || retire.
  - retire = mem_valid && allowout.
- Enqueue: ex_valid && ex_both_ready && mem_ready && !flush. Writes the tail entry; tail wraps modulo DEPTH.
- Retire: head entry invalidated; head pointer wraps.
  - Enqueue and retire in the same cycle leave count unchanged, including when the queue is full.
- Response routing on mmu_data_ok:
  - If discard_cnt>0: decrement discard_cnt; data dropped.
  - Else: oldest waiting entry, in queue order, sets done=1 and latches data=mmu_rdata.
  - data_ok with no waiting entry and discard_cnt==0 is a protocol error. The bench asserts it never happens.
- Flush, on the next edge:
  - All entries invalidated; count=0; pointers reset to 0.
  - discard_cnt <= discard_cnt + W - (mmu_data_ok ? 1 : 0), where W is the number of waiting entries before the edge.
  - A same-cycle data_ok is thus charged to the old discard backlog or to a flushed entry.
  - mem_valid is forced to 0 during a flush cycle; no retire occurs.
- Load extraction at the head uses the head's addr[1:0] and size:
  - Byte lane selected by addr[1:0].
  - Half lane selected by addr[1].
  - Word passes through unchanged.
  - Sign-extend only for MEM_LOAD_S.
  - Stores and NOPs output the stored result.
- mem_valid = head valid && head done && !flush.
- Latency with an empty queue and data already present: enqueue at edge N, mem_valid high in cycle N+1.

Optional Feature:
- MEM_QUEUE_BYPASS_EN defined:
  - A waiting head that receives mmu_data_ok in the current cycle (discard_cnt==0) is treated as done in that cycle.
  - Extraction uses mmu_rdata combinationally, and the entry can retire that cycle.
  - The data is also latched so a stall is safe.
- Not defined: the head becomes complete one cycle after its data_ok. This gives a registered path only.

Test Plan:
- Single LOAD_S byte, addr[1:0]=2'b11, then data_ok with rdata=0x80_12_34_56, allowout=1 -> mem_result=0xFFFFFF80 and mem_valid exactly one cycle (bypass: the data_ok cycle; else the next cycle).
- Four back-to-back stores with DEPTH=4 and allowout=0 -> mem_ready=0 after the 4th; a 5th is held. Then 4 data_ok and allowout=1 -> retire in order, one per cycle.
- Queue full, head done, allowout=1, new EX instruction -> simultaneous enqueue+retire; count stays 4; mem_ready=1.
- Two waiting loads, flush with data_ok in the same cycle -> discard_cnt=1. The next data_ok (rdata=0xDEADBEEF) is dropped. A newly enqueued LOAD_U half, addr[1]=1, takes the following data_ok 0x1234ABCD -> mem_result=0x00001234.
- NOP head with a waiting load behind it -> mem_forwardable=1 and the NOP retires before any data_ok.
- resetn deasserted mid-operation with 2 waiting entries -> mem_valid=0 and mem_ready=1 immediately, without waiting for a clock edge; no discard is carried over.
